// File: rtl/vball_sprite_dma.sv
// Double-buffered sprite attribute RAM: the CPU fills a work buffer, and each vblank
// copies it into the hidden display bank and then swaps banks so the sprite engine only sees whole frames.
module vball_sprite_dma #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic [AW-1:0] sma,
    output logic [DW-1:0] smd,
    output logic          busy,
    output logic          swap_done
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COPY = 2'd1;
    localparam logic [1:0] ST_SWAP = 2'd2;

    logic [DW-1:0] work_mem  [DEPTH];
    logic [DW-1:0] bank0_mem [DEPTH];
    logic [DW-1:0] bank1_mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic          vblank_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] rd_data_q;
    logic          front_sel_q, front_sel_d;
    logic          busy_q, busy_d;
    logic          swap_done_q, swap_done_d;
    logic [DW-1:0] cpu_dout_q;
    logic [DW-1:0] smd_q;

    logic          vblank_rise_c;
    logic          rd_done_c;
    logic          rd_issue_c;
    logic [AW-1:0] ram_addr_c;

    assign vblank_rise_c = vblank & ~vblank_q;
    assign rd_done_c     = (rd_ptr_q == PW'(DEPTH));
    // Work RAM has a single port; the CPU owns it whenever it is selected.
    assign ram_addr_c    = cpu_cs ? cpu_addr : rd_ptr_q[AW-1:0];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        front_sel_d = front_sel_q;
        busy_d      = busy_q;
        swap_done_d = 1'b0;
        rd_issue_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vblank_rise_c) begin
                    state_d  = ST_COPY;
                    busy_d   = 1'b1;
                    rd_ptr_d = '0;
                end
            end
            ST_COPY: begin
                if (!cpu_cs && !rd_done_c && vblank) begin
                    rd_issue_c = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                end
                // Abort outranks completion: a frame cut short never reaches the engine.
                if (!vblank) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (rd_valid_q && rd_done_c) begin
                    state_d     = ST_SWAP;
                    busy_d      = 1'b0;
                    swap_done_d = 1'b1;
                    front_sel_d = ~front_sel_q;
                end
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            vblank_q    <= 1'b0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            front_sel_q <= 1'b0;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblank_q    <= vblank;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_issue_c;
            front_sel_q <= front_sel_d;
            busy_q      <= busy_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Read ports; the CPU read returns the pre-write value on a write cycle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_dout_q <= '0;
            smd_q      <= '0;
        end else begin
            if (cpu_cs) begin
                cpu_dout_q <= work_mem[ram_addr_c];
            end
            smd_q <= front_sel_q ? bank1_mem[sma] : bank0_mem[sma];
        end
    end

    // RAM arrays and copy datapath; contents are deliberately not reset
    always_ff @(posedge clk_sys) begin
        if (cpu_cs && cpu_we) begin
            work_mem[cpu_addr] <= cpu_din;
        end
        if (rd_issue_c) begin
            rd_data_q <= work_mem[ram_addr_c];
            wr_addr_q <= rd_ptr_q[AW-1:0];
        end
        // The write stage drains even while the read stage is stalled.
        if (rd_valid_q) begin
            if (front_sel_q) begin
                bank0_mem[wr_addr_q] <= rd_data_q;
            end else begin
                bank1_mem[wr_addr_q] <= rd_data_q;
            end
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign smd       = smd_q;
    assign busy      = busy_q;
    assign swap_done = swap_done_q;

endmodule
